top_writeback: RTL and testbench

TOP_WRITEBACK -- requirements
Module: top_writeback

---
 rtl/top_writeback_pkg.sv | 22 ++
 rtl/regfile.sv | 38 +++
 rtl/top_writeback.sv | 95 +++++++++
 tb/tb_top_writeback.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/top_writeback_pkg.sv
// rtl/top_writeback_pkg.sv - shared opcode field layout, writeback select encodings and core widths
package top_writeback_pkg;

`ifdef RV64I
   localparam int XLEN_DEFAULT = 64;
`else
   localparam int XLEN_DEFAULT = 32;
`endif

   localparam int OPLEN      = 3;
   localparam int WB_SEL_LSB = 0;
   localparam int WB_SEL_W   = 2;
   localparam int CSR_RD_BIT = 2;

   typedef enum logic [1:0] {
      WB_NONE = 2'b00,
      WB_ALU  = 2'b01,
      WB_MEM  = 2'b10,
      WB_LINK = 2'b11
   } wb_sel_e;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry integer register file, two async reads, one sync write, x0 hardwired
module regfile #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];

   always_comb begin
      regs_d = regs_q;
      // Entry 0 is never written, so it stays at its reset value of zero.
      if (we && (waddr != 5'd0)) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/top_writeback.sv
// rtl/top_writeback.sv - writeback stage: result select, register write, pc and instret update
module top_writeback
   import top_writeback_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter int              OPLEN        = top_writeback_pkg::OPLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             phase_writeback,
   input  logic [OPLEN-1:0] decoded_op_mw,
   input  logic             jump_state_mw,
   input  logic [4:0]       rdsel_mw,
   input  logic [XLEN-1:0]  next_pc_mw,
   input  logic [XLEN-1:0]  alu_out_mw,
   input  logic [XLEN-1:0]  mem_out_mw,
   input  logic [XLEN-1:0]  csr_rdata_mw,
   input  logic [4:0]       rs1sel,
   input  logic [4:0]       rs2sel,
   output logic [XLEN-1:0]  rs1data,
   output logic [XLEN-1:0]  rs2data,
   output logic [XLEN-1:0]  pc,
   output logic [63:0]      instret,
   output logic             stall_writeback
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [63:0]     instret_q, instret_d;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] wb_data;
   logic            wb_en;
   logic            csr_rd;
   wb_sel_e         wb_sel;
   logic            unused_op_bits;

   assign wb_sel         = wb_sel_e'(decoded_op_mw[WB_SEL_LSB +: WB_SEL_W]);
   assign csr_rd         = decoded_op_mw[CSR_RD_BIT];
   assign unused_op_bits = ^decoded_op_mw;
   assign pc_plus4       = pc_q + XLEN'(4);

   always_comb begin
      wb_data = '0;
      case (wb_sel)
         WB_ALU:  wb_data = alu_out_mw;
         WB_MEM:  wb_data = mem_out_mw;
         WB_LINK: wb_data = pc_plus4;
         default: wb_data = '0;
      endcase
      // A CSR read overrides whatever the select field says.
      if (csr_rd) begin
         wb_data = csr_rdata_mw;
      end
      wb_en = phase_writeback && (csr_rd || (wb_sel != WB_NONE));
   end

   // Link data and the next pc both come from the pre-edge pc_q.
   always_comb begin
      pc_d      = pc_q;
      instret_d = instret_q;
      if (phase_writeback) begin
         pc_d      = jump_state_mw ? next_pc_mw : pc_plus4;
         instret_d = instret_q + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_VECTOR;
         instret_q <= '0;
      end else begin
         pc_q      <= pc_d;
         instret_q <= instret_d;
      end
   end

   regfile #(
      .XLEN (XLEN)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_en),
      .waddr  (rdsel_mw),
      .wdata  (wb_data),
      .raddr1 (rs1sel),
      .rdata1 (rs1data),
      .raddr2 (rs2sel),
      .rdata2 (rs2data)
   );

   assign pc              = pc_q;
   assign instret         = instret_q;
   assign stall_writeback = 1'b0;

endmodule

// File: tb/tb_top_writeback.sv
// tb/tb_top_writeback.sv - randomized self-checking bench for top_writeback against a behavioural model
module tb_top_writeback;

   localparam int          XL = 32;
   localparam logic [31:0] RV = 32'h0000_0080;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          phase_writeback;
   logic [2:0]    decoded_op_mw;
   logic          jump_state_mw;
   logic [4:0]    rdsel_mw;
   logic [XL-1:0] next_pc_mw, alu_out_mw, mem_out_mw, csr_rdata_mw;
   logic [4:0]    rs1sel, rs2sel;
   logic [XL-1:0] rs1data, rs2data, pc;
   logic [63:0]   instret;
   logic          stall_writeback;

   top_writeback #(
      .XLEN         (XL),
      .OPLEN        (3),
      .RESET_VECTOR (RV)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .phase_writeback (phase_writeback),
      .decoded_op_mw   (decoded_op_mw),
      .jump_state_mw   (jump_state_mw),
      .rdsel_mw        (rdsel_mw),
      .next_pc_mw      (next_pc_mw),
      .alu_out_mw      (alu_out_mw),
      .mem_out_mw      (mem_out_mw),
      .csr_rdata_mw    (csr_rdata_mw),
      .rs1sel          (rs1sel),
      .rs2sel          (rs2sel),
      .rs1data         (rs1data),
      .rs2data         (rs2data),
      .pc              (pc),
      .instret         (instret),
      .stall_writeback (stall_writeback)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [XL-1:0] m_regs [32];
   logic [XL-1:0] m_pc;
   logic [63:0]   m_instret;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc      = RV;
      m_instret = '0;
   endtask

   task automatic check_reg(input string tag, input logic [4:0] idx);
      rs1sel = idx;
      rs2sel = 5'($urandom_range(0, 31));
      #1;
      check(tag, 64'(rs1data), 64'(m_regs[idx]));
      check("rs2_read", 64'(rs2data), 64'(m_regs[rs2sel]));
   endtask

   task automatic check_state(input string tag);
      check({tag, "_pc"}, 64'(pc), 64'(m_pc));
      check({tag, "_instret"}, instret, m_instret);
      check({tag, "_stall"}, 64'(stall_writeback), 64'd0);
   endtask

   task automatic do_wb(input logic csr, input logic [1:0] sel, input logic jmp, input logic [4:0] rd,
                        input logic [XL-1:0] npc, input logic [XL-1:0] alu, input logic [XL-1:0] mem,
                        input logic [XL-1:0] csrd);
      logic [XL-1:0] data;
      @(negedge clk);
      decoded_op_mw   = {csr, sel};
      jump_state_mw   = jmp;
      rdsel_mw        = rd;
      next_pc_mw      = npc;
      alu_out_mw      = alu;
      mem_out_mw      = mem;
      csr_rdata_mw    = csrd;
      phase_writeback = 1'b1;
      if (csr)             data = csrd;
      else if (sel == 2'd1) data = alu;
      else if (sel == 2'd2) data = mem;
      else                  data = m_pc + 32'd4;
      @(posedge clk);
      #1;
      phase_writeback = 1'b0;
      if ((csr || sel != 2'd0) && rd != 5'd0) m_regs[rd] = data;
      m_pc      = jmp ? npc : m_pc + 32'd4;
      m_instret = m_instret + 64'd1;
      check_state("wb");
      check_reg("rd_read", rd);
   endtask

   initial begin
      rst_n           = 1'b0;
      phase_writeback = 1'b0;
      decoded_op_mw   = '0;
      jump_state_mw   = 1'b0;
      rdsel_mw        = '0;
      next_pc_mw      = '0;
      alu_out_mw      = '0;
      mem_out_mw      = '0;
      csr_rdata_mw    = '0;
      rs1sel          = '0;
      rs2sel          = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset state
      check_state("reset");
      check_reg("reset_x5", 5'd5);

      // directed cases
      do_wb(1'b0, 2'b01, 1'b0, 5'd5, '0, 32'h1234, 32'h5555, 32'h7777);
      check("alu_x5", 64'(rs1data), 64'h1234);
      do_wb(1'b0, 2'b00, 1'b1, 5'd3, 32'h100, 32'hDEAD, 32'hBEEF, 32'h0);
      check("jump_pc", 64'(pc), 64'h100);
      do_wb(1'b0, 2'b11, 1'b1, 5'd1, 32'h200, 32'h9, 32'h9, 32'h9);
      check("link_x1", 64'(rs1data), 64'h104);
      check("link_pc", 64'(pc), 64'h200);
      do_wb(1'b0, 2'b10, 1'b0, 5'd0, 32'h0, 32'h0, 32'hFFFF, 32'h0);
      check("x0_zero", 64'(rs1data), 64'h0);
      check("x0_pc", 64'(pc), 64'h204);
      do_wb(1'b1, 2'b01, 1'b0, 5'd7, 32'h0, 32'h1111, 32'h2222, 32'hABCD);
      check("csr_x7", 64'(rs1data), 64'hABCD);

      // hold with phase low while inputs toggle
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         decoded_op_mw = 3'($urandom);
         jump_state_mw = 1'($urandom);
         rdsel_mw      = 5'($urandom);
         next_pc_mw    = $urandom;
         alu_out_mw    = $urandom;
         mem_out_mw    = $urandom;
         csr_rdata_mw  = $urandom;
         @(posedge clk);
         #1;
         check_state("hold");
         check_reg("hold_reg", 5'($urandom_range(0, 31)));
      end

      // randomized writebacks
      for (int i = 0; i < 200; i++) begin
         do_wb(($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 3) == 0),
               5'($urandom), $urandom, $urandom, $urandom, $urandom);
      end

      // instret wrap
      @(negedge clk);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      check("instret_forced", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      release dut.instret_q;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      do_wb(1'b0, 2'b01, 1'b0, 5'd9, '0, 32'h42, 32'h0, 32'h0);
      check("instret_wrap", instret, 64'h0);

      // reset asserted while a write is pending
      @(negedge clk);
      decoded_op_mw   = 3'b001;
      rdsel_mw        = 5'd12;
      alu_out_mw      = 32'hCAFE_F00D;
      jump_state_mw   = 1'b1;
      next_pc_mw      = 32'h4000;
      phase_writeback = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state("async_rst");
      @(posedge clk);
      #1;
      check_state("rst_phase");
      check_reg("rst_x12", 5'd12);
      check_reg("rst_x5", 5'd5);
      phase_writeback = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state("post_rst_idle");
      do_wb(1'b0, 2'b11, 1'b0, 5'd31, '0, '0, '0, '0);
      check("post_rst_link", 64'(rs1data), 64'(RV + 32'd4));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
